// File: rtl/mpe_pkg.sv
// Shared defaults and FSM encoding for the SRAM streaming read path.
package mpe_pkg;

  localparam int unsigned DEF_DATA_W = 512;
  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_LEN_W  = 8;
  localparam int unsigned FIFO_CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry valid/ready FIFO; the head register drives the consumer directly.
module stream_fifo2
  import mpe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [DATA_W-1:0]     mem_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [FIFO_CNT_W-1:0] count_q;
  logic                  push;
  logic                  pop;

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign in_ready  = (count_q != FIFO_CNT_W'(2)) || out_ready;
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (push && !pop) begin
        count_q <= count_q + FIFO_CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - FIFO_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sram_stream_rd.sv
// Streams cmd_len consecutive SRAM lines to a valid/ready consumer,
// keeping at most two lines queued or in flight.
module sram_stream_rd
  import mpe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              sram_ren,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done
);

  localparam int unsigned OCC_W = FIFO_CNT_W + 1;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [LEN_W-1:0]      rd_left_q, rd_left_d;
  logic [LEN_W-1:0]      beat_left_q, beat_left_d;
  logic                  done_q, done_d;
  logic                  inflight_q;
  logic                  ren;
  logic                  pop;
  logic                  fifo_in_ready;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [OCC_W-1:0]      occupancy;

  assign pop       = out_valid && out_ready;
  // Lines queued plus the one returning, after this cycle's departure.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign sram_ren  = ren && !rst;
  assign sram_addr = addr_q;
  assign done      = done_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_left_d   = rd_left_q;
    beat_left_d = beat_left_q;
    done_d      = 1'b0;
    ren         = 1'b0;
    if (pop) begin
      beat_left_d = beat_left_q - LEN_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = RUN;
            addr_d      = cmd_addr;
            rd_left_d   = cmd_len;
            beat_left_d = cmd_len;
          end
        end
      end
      RUN: begin
        if (occupancy < OCC_W'(2)) begin
          ren       = 1'b1;
          addr_d    = addr_q + ADDR_W'(1);
          rd_left_d = rd_left_q - LEN_W'(1);
          if (rd_left_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && (beat_left_q == LEN_W'(1))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rd_left_q   <= '0;
      beat_left_q <= '0;
      done_q      <= 1'b0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_left_q   <= rd_left_d;
      beat_left_q <= beat_left_d;
      done_q      <= done_d;
      inflight_q  <= ren;
    end
  end

  // Clearing inflight_q on reset drops any read that returns afterwards.
  stream_fifo2 #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inflight_q),
    .in_ready (fifo_in_ready),
    .in_data  (sram_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_sram_stream_rd.sv
// Directed bench for sram_stream_rd: SRAM model returns the line address as data.
module tb_sram_stream_rd;
  import mpe_pkg::*;

  localparam int unsigned DATA_W = DEF_DATA_W;
  localparam int unsigned ADDR_W = DEF_ADDR_W;
  localparam int unsigned LEN_W  = DEF_LEN_W;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              sram_ren;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [ADDR_W-1:0] ren_addr_q[$];
  int                ren_cyc_q[$];
  logic [DATA_W-1:0] beat_q[$];
  int                beat_cyc_q[$];
  int done_cnt, done_cyc, valid_cnt, notready_cnt, stab_err, outstanding, max_out;
  logic prev_v, prev_r;
  logic [DATA_W-1:0] prev_d;

  sram_stream_rd #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .sram_ren  (sram_ren),
    .sram_addr (sram_addr),
    .sram_rdata(sram_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: data is the address one cycle after ren, garbage otherwise.
  always @(posedge clk)
    sram_rdata <= sram_ren ? DATA_W'(sram_addr) : {(DATA_W/32){32'hDEAD_BEEF}};

  // Mid-cycle monitor logging reads, beats, done pulses and handshake stability.
  always @(negedge clk) begin
    if (!rst) begin
      if (!cmd_ready) notready_cnt++;
      if (sram_ren) begin
        ren_addr_q.push_back(sram_addr);
        ren_cyc_q.push_back(cyc);
        outstanding++;
      end
      if (out_valid) valid_cnt++;
      if (out_valid && out_ready) begin
        beat_q.push_back(out_data);
        beat_cyc_q.push_back(cyc);
        outstanding--;
      end
      if (outstanding > max_out) max_out = outstanding;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_v && !prev_r && (!out_valid || out_data !== prev_d)) stab_err++;
      prev_v = out_valid;
      prev_r = out_ready;
      prev_d = out_data;
    end else begin
      prev_v      = 1'b0;
      outstanding = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    ren_addr_q.delete();
    ren_cyc_q.delete();
    beat_q.delete();
    beat_cyc_q.delete();
    done_cnt = 0; done_cyc = -1; valid_cnt = 0; notready_cnt = 0;
    stab_err = 0; outstanding = 0; max_out = 0; prev_v = 1'b0;
  endtask

  task automatic send_cmd(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l, output int c);
    tick();
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    c         = cyc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, output bit timeout);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    timeout = (done_cnt == 0);
    out_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b0;
    tick();
    tick();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %b exp 0", cmd_ready); end
    checks++; if (sram_ren !== 1'b0) begin errors++; $display("FAIL rst_sram_ren got %b exp 0", sram_ren); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    checks++; if (sram_addr !== '0) begin errors++; $display("FAIL rst_sram_addr got %h exp 0", sram_addr); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data got %h exp 0", out_data); end
    rst = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_basic();
    bit to; int c; logic [DATA_W-1:0] exp;
    clear_logs(); out_ready = 1'b1;
    send_cmd(16'h0010, 8'd4, c);
    wait_done(50, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got no done exp done"); end
    checks++; if (ren_cyc_q.size() == 0 || ren_cyc_q[0] != c + 1) begin errors++; $display("FAIL basic_first_ren got %0d reads exp first at cyc %0d", ren_cyc_q.size(), c + 1); end
    checks++; if (beat_q.size() != 4) begin errors++; $display("FAIL basic_beats got %0d exp 4", beat_q.size()); end
    for (int i = 0; i < beat_q.size(); i++) begin
      exp = DATA_W'(ADDR_W'(16'h0010 + i));
      checks++; if (beat_q[i] !== exp) begin errors++; $display("FAIL basic_data%0d got %h exp %h", i, beat_q[i][31:0], exp[31:0]); end
      checks++; if (beat_cyc_q[i] != c + 3 + i) begin errors++; $display("FAIL basic_cyc%0d got %0d exp %0d", i, beat_cyc_q[i], c + 3 + i); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt got %0d exp 1", done_cnt); end
    checks++; if (done_cyc != c + 7) begin errors++; $display("FAIL basic_done_cyc got %0d exp %0d", done_cyc, c + 7); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL basic_idle_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_zero_len();
    bit to; int c;
    clear_logs(); out_ready = 1'b1;
    send_cmd(16'h0055, 8'd0, c);
    wait_done(20, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL zero_timeout got no done exp done"); end
    checks++; if (ren_addr_q.size() != 0) begin errors++; $display("FAIL zero_reads got %0d exp 0", ren_addr_q.size()); end
    checks++; if (valid_cnt != 0) begin errors++; $display("FAIL zero_valid got %0d exp 0", valid_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_cnt got %0d exp 1", done_cnt); end
    checks++; if (done_cyc != c + 1) begin errors++; $display("FAIL zero_done_cyc got %0d exp %0d", done_cyc, c + 1); end
    checks++; if (notready_cnt != 0) begin errors++; $display("FAIL zero_ready_drop got %0d exp 0", notready_cnt); end
  endtask

  task automatic test_backpressure();
    bit to; int c; int n = 0; logic [DATA_W-1:0] exp;
    clear_logs(); out_ready = 1'b0;
    send_cmd(16'h0010, 8'd8, c);
    while (!out_valid && n < 20) begin tick(); n++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid got %b exp 1", out_valid); end
    repeat (10) tick();
    checks++; if (out_data !== DATA_W'(16'h0010)) begin errors++; $display("FAIL bp_hold_data got %h exp 10", out_data[31:0]); end
    checks++; if (ren_addr_q.size() != 2) begin errors++; $display("FAIL bp_reads_stalled got %0d exp 2", ren_addr_q.size()); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL bp_stable_stall got %0d exp 0", stab_err); end
    out_ready = 1'b1;
    wait_done(60, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout got no done exp done"); end
    checks++; if (beat_q.size() != 8) begin errors++; $display("FAIL bp_beats got %0d exp 8", beat_q.size()); end
    for (int i = 0; i < beat_q.size(); i++) begin
      exp = DATA_W'(ADDR_W'(16'h0010 + i));
      checks++; if (beat_q[i] !== exp) begin errors++; $display("FAIL bp_data%0d got %h exp %h", i, beat_q[i][31:0], exp[31:0]); end
    end
    checks++; if (max_out > 2) begin errors++; $display("FAIL bp_outstanding got %0d exp <=2", max_out); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_cnt got %0d exp 1", done_cnt); end
  endtask

  task automatic test_wrap();
    bit to; int c;
    logic [ADDR_W-1:0] exp_a [4];
    exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
    clear_logs(); out_ready = 1'b1;
    send_cmd(16'hFFFE, 8'd4, c);
    wait_done(50, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL wrap_timeout got no done exp done"); end
    checks++; if (ren_addr_q.size() != 4) begin errors++; $display("FAIL wrap_reads got %0d exp 4", ren_addr_q.size()); end
    for (int i = 0; i < ren_addr_q.size() && i < 4; i++) begin
      checks++; if (ren_addr_q[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr%0d got %h exp %h", i, ren_addr_q[i], exp_a[i]); end
    end
    for (int i = 0; i < beat_q.size() && i < 4; i++) begin
      checks++; if (beat_q[i] !== DATA_W'(exp_a[i])) begin errors++; $display("FAIL wrap_data%0d got %h exp %h", i, beat_q[i][31:0], exp_a[i]); end
    end
  endtask

  task automatic test_random();
    bit to; int c; int bad = 0; logic [DATA_W-1:0] exp;
    clear_logs(); out_ready = 1'b0;
    send_cmd(16'h0100, 8'd140, c);
    wait_done(3000, 1'b1, to);
    checks++; if (to) begin errors++; $display("FAIL rand_timeout got no done exp done"); end
    checks++; if (beat_q.size() != 140) begin errors++; $display("FAIL rand_beats got %0d exp 140", beat_q.size()); end
    for (int i = 0; i < beat_q.size(); i++) begin
      exp = DATA_W'(ADDR_W'(16'h0100 + i));
      if (beat_q[i] !== exp) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rand_order got %0d bad beats exp 0", bad); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL rand_done_cnt got %0d exp 1", done_cnt); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL rand_stable got %0d exp 0", stab_err); end
    checks++; if (max_out > 2) begin errors++; $display("FAIL rand_outstanding got %0d exp <=2", max_out); end
  endtask

  task automatic test_reset_mid();
    bit to; int c; int n = 0;
    clear_logs(); out_ready = 1'b1;
    send_cmd(16'h0040, 8'd16, c);
    while (beat_q.size() < 3 && n < 30) begin tick(); n++; end
    checks++; if (beat_q.size() < 3) begin errors++; $display("FAIL mid_third_beat got %0d exp 3", beat_q.size()); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL mid_cmd_ready got %b exp 0", cmd_ready); end
    checks++; if (sram_ren !== 1'b0) begin errors++; $display("FAIL mid_sram_ren got %b exp 0", sram_ren); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b exp 0", out_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done got %b exp 0", done); end
    checks++; if (sram_addr !== '0) begin errors++; $display("FAIL mid_sram_addr got %h exp 0", sram_addr); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL mid_out_data got %h exp 0", out_data[31:0]); end
    tick();
    rst = 1'b0;
    clear_logs();
    repeat (5) tick();
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL mid_no_done got %0d exp 0", done_cnt); end
    checks++; if (valid_cnt != 0) begin errors++; $display("FAIL mid_stale_valid got %0d exp 0", valid_cnt); end
    clear_logs();
    send_cmd(16'h0020, 8'd2, c);
    wait_done(40, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL mid_new_timeout got no done exp done"); end
    checks++; if (beat_q.size() != 2) begin errors++; $display("FAIL mid_new_beats got %0d exp 2", beat_q.size()); end
    for (int i = 0; i < beat_q.size(); i++) begin
      checks++; if (beat_q[i] !== DATA_W'(ADDR_W'(16'h0020 + i))) begin errors++; $display("FAIL mid_new_data%0d got %h exp %h", i, beat_q[i][31:0], 16'h0020 + i); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL mid_new_done got %0d exp 1", done_cnt); end
  endtask

  initial begin
    clear_logs();
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_stream_rd.md
SRAM_STREAM_RD -- requirements
Module: sram_stream_rd

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 512, meaning the SRAM line and stream beat width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 16, meaning the SRAM line address width.
REQ-003 The block SHALL have parameter LEN_W, default 8, meaning the command length width in lines.

Interface
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port cmd_valid, input, 1 bit: a read command is offered.
REQ-007 The block SHALL have port cmd_ready, output, 1 bit: the block accepts a command.
REQ-008 The block SHALL have port cmd_addr, input, ADDR_W bits: first line address.
REQ-009 The block SHALL have port cmd_len, input, LEN_W bits: number of lines to stream.
REQ-010 The block SHALL have port sram_ren, output, 1 bit: SRAM read enable.
REQ-011 The block SHALL have port sram_addr, output, ADDR_W bits: SRAM read address.
REQ-012 The block SHALL have port sram_rdata, input, DATA_W bits: read data, valid exactly 1 cycle after sram_ren.
REQ-013 The block SHALL have port out_data, output, DATA_W bits: stream beat to the consumer (neuron or weight port of matrix_pe).
REQ-014 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid beat.
REQ-015 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the beat.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle pulse marking command completion.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DRAIN; cmd_ready SHALL equal (state==IDLE).
REQ-018 In IDLE, when cmd_valid is high, the block SHALL latch cmd_addr and cmd_len and go to RUN; if cmd_len==0, it SHALL instead stay in IDLE, pulse done the next cycle and issue no read.
REQ-019 In RUN, sram_ren SHALL be asserted only when the queued-plus-in-flight count, after this cycle's pop, is below 2; sram_addr SHALL start at cmd_addr and increment by 1 per issued read, wrapping modulo 2^ADDR_W.
REQ-020 After cmd_len reads have been issued, the FSM SHALL go from RUN to DRAIN; from DRAIN it SHALL go to IDLE in the cycle after the final out_valid&&out_ready handshake, with done high for exactly that one cycle.
REQ-021 Returned data SHALL be written into a 2-entry FIFO, and out_valid/out_data SHALL come from the FIFO head; the FIFO SHALL never overflow.
REQ-022 Latency: with out_ready high, the first sram_ren SHALL occur in the cycle after the cmd handshake, and the first out_valid 2 cycles after that ren.
REQ-023 Throughput: with out_ready held high, the block SHALL sustain 1 beat per cycle.
REQ-024 Handshake: once out_valid is high, out_valid and out_data SHALL stay stable until out_ready is high; out_valid SHALL NOT depend combinationally on out_ready.
REQ-025 Beats SHALL be delivered in address order, exactly cmd_len beats per command.
REQ-026 Simultaneous FIFO push and pop SHALL keep the count unchanged, including when the FIFO is full.

Reset
REQ-027 While rst is high, state SHALL be IDLE; cmd_ready, sram_ren, out_valid and done SHALL be 0; sram_addr, FIFO count and in-flight flag SHALL be 0; out_data SHALL be 0.
REQ-028 rst asserted mid-command SHALL abort the command, discard queued and in-flight data, and produce no done pulse; a read returning after reset SHALL be ignored.

Structure
REQ-029 Package mpe_pkg SHALL hold DATA_W, ADDR_W and LEN_W defaults and the FSM state enum.
REQ-030 The FIFO SHALL be a separate sub-module, stream_fifo2 (2-entry, valid/ready, synchronous active-high reset).

Verification
REQ-031 Directed test: cmd_addr=0x0010, cmd_len=4, out_ready=1, SRAM model data=addr -> beats 0x10..0x13 on consecutive cycles; first out_valid 3 cycles after cmd; done 1 cycle after the last beat.
REQ-032 Directed test: cmd_len=0 -> no sram_ren, no out_valid, done pulse 1 cycle after cmd, cmd_ready high throughout.
REQ-033 Directed test: cmd_len=8 with out_ready held low for 10 cycles after the first valid -> at most 2 reads outstanding, out_data stable at 0x10, then the remaining beats in order.
REQ-034 Directed test: cmd_addr=0xFFFE, cmd_len=4 -> sram_addr sequence FFFE, FFFF, 0000, 0001.
REQ-035 Directed test: out_ready random 50%, cmd_len=140, compared with a scoreboard -> 140 beats in order and exactly one done pulse.
REQ-036 Directed test: rst asserted 2 cycles after the third beat of a cmd_len=16 command -> all outputs at reset values the next cycle; a new command cmd_addr=0x0020, cmd_len=2 then returns 0x20 and 0x21.
